// File: rtl/gpsdo_uart_tx.sv
// Buffered 8N1 UART transmitter for the GPSDO host/debug link, timed from CLK_SYS.
// Define UART_PARITY_EN to insert an even-parity bit after D7 (8E1, 11-bit frame).
module gpsdo_uart_tx #(
  parameter int CLK_FREQ   = 10000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK_SYS,
  input  logic       CLK_RST,
  input  logic       Uart_En,
  input  logic [7:0] Uart_Data,
  output logic       Uart_Busy,
  output logic       Uart_Tx,
  output logic       Tx_Active,
  output logic [7:0] Ovf_Cnt
);

  localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int NW       = PW + 1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          bit_end;

  logic          en_d;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [NW-1:0] count;
  logic [NW-1:0] count_next;
  logic          wr;
  logic          pop;
  logic          push;
  logic          fifo_full;

  assign wr        = Uart_En & ~en_d;
  assign fifo_full = (count == NW'(FIFO_DEPTH));
  assign pop       = (state == IDLE) && (count != '0);
  // A full FIFO still accepts a write when the same edge pops a byte.
  assign push      = wr && (!fifo_full || pop);
  assign bit_end   = (baud_cnt == CW'(BAUD_DIV - 1));

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge CLK_SYS) begin
    if (push)
      fifo_mem[wr_ptr] <= Uart_Data;
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      en_d      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      Uart_Busy <= 1'b0;
      Ovf_Cnt   <= 8'd0;
    end else begin
      en_d      <= Uart_En;
      count     <= count_next;
      Uart_Busy <= (count_next == NW'(FIFO_DEPTH));
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr && !push && (Ovf_Cnt != 8'hFF))
        Ovf_Cnt <= Ovf_Cnt + 8'd1;
    end
  end

  // Line outputs are registered from the state, so the line trails the FSM by one clock.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'd0;
      Uart_Tx   <= 1'b1;
      Tx_Active <= 1'b0;
    end else begin
      if (state != IDLE)
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            baud_cnt  <= '0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_idx <= 3'd0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (bit_end)
            state <= STOP;
        end
`endif
        STOP: begin
          if (bit_end)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      case (state)
        START:   Uart_Tx <= 1'b0;
        DATA:    Uart_Tx <= shift_reg[bit_idx];
`ifdef UART_PARITY_EN
        PARITY:  Uart_Tx <= ^shift_reg;
`endif
        default: Uart_Tx <= 1'b1;
      endcase
      Tx_Active <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_gpsdo_uart_tx.sv
// Directed self-checking bench for gpsdo_uart_tx at BAUD_DIV=10 (8N1, or 8E1 with UART_PARITY_EN).
module tb_gpsdo_uart_tx;

  localparam int BD = 10;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FP = NB * BD + 1;

  logic       CLK_SYS   = 1'b0;
  logic       CLK_RST   = 1'b0;
  logic       Uart_En   = 1'b0;
  logic [7:0] Uart_Data = 8'd0;
  logic       Uart_Busy;
  logic       Uart_Tx;
  logic       Tx_Active;
  logic [7:0] Ovf_Cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  gpsdo_uart_tx #(
    .CLK_FREQ   (10000000),
    .BAUD       (1000000),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK_SYS   (CLK_SYS),
    .CLK_RST   (CLK_RST),
    .Uart_En   (Uart_En),
    .Uart_Data (Uart_Data),
    .Uart_Busy (Uart_Busy),
    .Uart_Tx   (Uart_Tx),
    .Tx_Active (Tx_Active),
    .Ovf_Cnt   (Ovf_Cnt)
  );

  always #5 CLK_SYS = ~CLK_SYS;
  always @(posedge CLK_SYS) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle write pulse; returns #1 after the edge that takes the byte.
  task automatic pulse(input logic [7:0] d);
    @(posedge CLK_SYS); #1;
    Uart_En   = 1'b1;
    Uart_Data = d;
    @(posedge CLK_SYS); #1;
    Uart_En   = 1'b0;
  endtask

  // Waits for a start bit, then checks every cycle of the frame and the idle cycle after it.
  task automatic expect_frame(input logic [7:0] b, input string tag, output int start_cyc);
    logic [10:0] bits;
    int waited;
`ifdef UART_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b0, 1'b1, b, 1'b0};
`endif
    waited = 0;
    @(negedge CLK_SYS);
    while (Uart_Tx !== 1'b0 && waited < 3000) begin
      @(negedge CLK_SYS);
      waited++;
    end
    chk({tag, "_start"}, Uart_Tx, 1'b0);
    start_cyc = cyc;
    for (int k = 0; k < NB * BD; k++) begin
      if (k > 0) @(negedge CLK_SYS);
      chk($sformatf("%s_bit%0d_c%0d", tag, k / BD, k % BD), Uart_Tx, bits[k / BD]);
      chk($sformatf("%s_act_c%0d", tag, k), Tx_Active, 1'b1);
    end
    @(negedge CLK_SYS);
    chk({tag, "_idle_tx"}, Uart_Tx, 1'b1);
    chk({tag, "_idle_act"}, Tx_Active, 1'b0);
  endtask

  task automatic expect_quiet(input int n, input string tag);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK_SYS);
      if (Uart_Tx !== 1'b1) lows++;
    end
    chk({tag, "_quiet"}, lows, 0);
  endtask

  initial begin
    int c0;
    int s;
    int st [6];

    repeat (3) @(negedge CLK_SYS);
    chk("rst_tx", Uart_Tx, 1'b1);
    chk("rst_busy", Uart_Busy, 1'b0);
    chk("rst_act", Tx_Active, 1'b0);
    chk("rst_ovf", Ovf_Cnt, 8'd0);
    CLK_RST = 1'b1;
    repeat (2) @(negedge CLK_SYS);

    // Single byte, latency, exact bit timing; data change mid-frame must not matter.
    @(posedge CLK_SYS); #1;
    Uart_En   = 1'b1;
    Uart_Data = 8'h0D;
    @(posedge CLK_SYS); #1;
    c0        = cyc;
    Uart_En   = 1'b0;
    Uart_Data = 8'hFF;
    @(negedge CLK_SYS);
    chk("t1_pre0_tx", Uart_Tx, 1'b1);
    @(negedge CLK_SYS);
    chk("t1_pre1_tx", Uart_Tx, 1'b1);
    chk("t1_pre1_act", Tx_Active, 1'b0);
    expect_frame(8'h0D, "t1", s);
    chk("t1_latency", s - c0, 2);
    expect_quiet(50, "t1");

    // Enable held high for 500 cycles gives one frame only.
    @(posedge CLK_SYS); #1;
    Uart_En   = 1'b1;
    Uart_Data = 8'h55;
    expect_frame(8'h55, "t2", s);
    expect_quiet(380, "t2");
    Uart_En = 1'b0;
    chk("t2_ovf", Ovf_Cnt, 8'd0);
    chk("t2_busy", Uart_Busy, 1'b0);

    // Five pulses two cycles apart: busy only after the fifth; 101-cycle frame period.
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          pulse(8'(i));
          chk($sformatf("t3_busy_w%0d", i), Uart_Busy, (i == 5) ? 1'b1 : 1'b0);
        end
      end
      begin
        for (int i = 0; i < 5; i++)
          expect_frame(8'(i + 1), $sformatf("t3_f%0d", i + 1), st[i]);
      end
    join
    for (int i = 1; i < 5; i++)
      chk($sformatf("t3_period%0d", i), st[i] - st[i - 1], FP);
    chk("t3_ovf", Ovf_Cnt, 8'd0);
    expect_quiet(50, "t3");

    // Six pulses into a depth-4 FIFO: sixth byte dropped and counted.
    fork
      begin
        for (int i = 1; i <= 6; i++) pulse(8'h10 + 8'(i));
        chk("t4_ovf", Ovf_Cnt, 8'd1);
        chk("t4_busy", Uart_Busy, 1'b1);
      end
      begin
        for (int i = 0; i < 5; i++)
          expect_frame(8'h11 + 8'(i), $sformatf("t4_f%0d", i + 1), st[i]);
      end
    join
    expect_quiet(300, "t4");
    chk("t4_ovf_end", Ovf_Cnt, 8'd1);

    // Reset during DATA bit 3 of 0x00 with two bytes queued.
    pulse(8'h00);
    c0 = cyc;
    pulse(8'hAA);
    pulse(8'hBB);
    chk("t5_busy_pre", Uart_Busy, 1'b0);
    while (cyc < c0 + 45) @(negedge CLK_SYS);
    chk("t5_bit3_tx", Uart_Tx, 1'b0);
    chk("t5_bit3_act", Tx_Active, 1'b1);
    CLK_RST = 1'b0;
    #1;
    chk("t5_rst_tx", Uart_Tx, 1'b1);
    chk("t5_rst_act", Tx_Active, 1'b0);
    chk("t5_rst_busy", Uart_Busy, 1'b0);
    chk("t5_rst_ovf", Ovf_Cnt, 8'd0);
    repeat (2) @(negedge CLK_SYS);
    CLK_RST = 1'b1;
    expect_quiet(300, "t5");
    pulse(8'h3C);
    expect_frame(8'h3C, "t5_new", s);

    // Parity-sensitive pair (parity bits 0 and 1 when UART_PARITY_EN is defined).
    fork
      begin
        pulse(8'h03);
        pulse(8'h07);
      end
      begin
        expect_frame(8'h03, "t6_a", st[0]);
        expect_frame(8'h07, "t6_b", st[1]);
      end
    join
    chk("t6_period", st[1] - st[0], FP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpsdo_uart_tx.md
Name: gpsdo_uart_tx

Overview:
Serial transmitter feeding the GPSDO host/debug UART link. Receives bytes from the phase-measurement logic on the Uart_En/Uart_Data/Uart_Busy interface and buffers them in a small FIFO. Serialises each byte as 8N1 (or 8E1, see Optional Feature) on Uart_Tx, timed from the 10 MHz disciplined CLK_SYS.

Parameters:
CLK_FREQ, 10000000, CLK_SYS frequency in Hz
BAUD, 115200, line rate in bit/s; BAUD_DIV = (CLK_FREQ + BAUD/2) / BAUD, rounded (87 at defaults), must be >= 2
FIFO_DEPTH, 4, byte FIFO depth; power of two, 2..16

Ports:
CLK_SYS  in  1  system clock (same as disciplined oscillator)
CLK_RST  in  1  reset, asynchronous, active-low
Uart_En  in  1  write request; a byte is taken on each 0->1 transition only
Uart_Data  in  8  byte to send, sampled in the cycle the transition is detected
Uart_Busy  out  1  high while FIFO full (registered)
Uart_Tx  out  1  serial line, idle high (registered)
Tx_Active  out  1  high while a frame is on the line (start through stop)
Ovf_Cnt  out  8  count of dropped bytes, saturating at 255

Behaviour:
- Reset (async, CLK_RST=0):
  - Uart_Tx=1, Uart_Busy=0, Tx_Active=0, Ovf_Cnt=0
  - FIFO empty; FSM=IDLE; edge register en_d=0
- Write detect: wr = Uart_En & ~en_d, with en_d <= Uart_En every cycle. Holding Uart_En high for any number of cycles gives exactly one write.
- On wr with FIFO not full: Uart_Data written at that clock edge.
- On wr with FIFO full: byte dropped, FIFO unchanged, Ovf_Cnt += 1 (saturating).
  - Exception: FIFO full and a pop in the same cycle -> write accepted, count unchanged.
- Uart_Busy = (count == FIFO_DEPTH), registered; reflects the count after the edge.
- Baud counter 0..BAUD_DIV-1; reloads at the start of every bit. Each bit lasts exactly BAUD_DIV cycles.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE: Uart_Tx=1. If FIFO non-empty: pop into shift register -> START.
  - START: Uart_Tx=0 for BAUD_DIV cycles -> DATA, bit index 0.
  - DATA: Uart_Tx = shift[idx], LSB first, BAUD_DIV cycles per bit; after idx 7 -> STOP (or PARITY).
  - STOP: Uart_Tx=1 for BAUD_DIV cycles -> IDLE.
- Latency: Uart_En first sampled high at edge N -> write at N -> pop at N+1 -> Uart_Tx low from edge N+2.
- Back-to-back frames: IDLE always occupies exactly one clock. Frame period = 10*BAUD_DIV+1 cycles (11*BAUD_DIV+1 with parity).
- Tx_Active = 1 in START/DATA/PARITY/STOP, 0 in IDLE.
- Empty FIFO: no pop, line stays high indefinitely.
- FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
- Uart_Data changing mid-frame has no effect on the frame in progress.
- Reset mid-frame: line returns high immediately; queued bytes discarded.

Optional Feature:
UART_PARITY_EN defined:
- PARITY state inserted after D7; Uart_Tx = ^byte (even parity) for BAUD_DIV cycles.
- Frame is 11 bits.

UART_PARITY_EN undefined:
- No PARITY state; 8N1, 10-bit frame.

Test Plan:
- BAUD=1000000 (BAUD_DIV=10), single 0->1 on Uart_En with Uart_Data=0x0D -> Uart_Tx low at N+2 for 10 cycles; then bits 1,0,1,1,0,0,0,0 at 10 cycles each; then high 10 cycles; Tx_Active high for 100 cycles.
- Uart_En held high 500 cycles with Uart_Data=0x55 -> exactly one frame; Ovf_Cnt=0.
- Five 1-cycle Uart_En pulses 2 cycles apart, data 0x01..0x05, DEPTH=4:
  - Uart_Busy rises after the 5th write, since the first pop freed a slot.
  - All five frames sent in order, separated by exactly 1 idle cycle each (101-cycle period).
- Six pulses, all written before the first frame ends, DEPTH=4 -> Ovf_Cnt=1; bytes 1-5 sent, byte 6 lost.
- Assert CLK_RST low during DATA bit 3 of 0x00 with 2 bytes queued:
  - Uart_Tx high immediately; all outputs at reset values.
  - After release, no frame until a new write.
- UART_PARITY_EN defined, bytes 0x03 and 0x07 -> parity bits 0 and 1 respectively; frame 110 cycles.
